hex_keypad_reader: RTL
======================

// Module: hex_keypad_reader
// PURPOSE
//  Input-side counterpart of the 8-digit hex display path: scans a 4x4 matrix keypad and assembles hex digits into a 32-bit word.
//  Drives one keypad column low at a time, samples the active-low rows, debounces, and decodes one key per press.
//  Shifts the key into data32, which the CPU/IO bus reads and the display module shows.
// PARAMETERS
//  SCAN_DIV     1000  clk cycles each column is held low before advancing (>=4)
//  DEBOUNCE_CYC 20000 consecutive stable clk cycles required for press and for release (>=2)
// PORTS
//  clk        in   1   system clock, single clock domain
//  clr        in   1   asynchronous, active-low reset
//  row        in   4   keypad rows, active-low, asynchronous to clk
//  col        out  4   keypad column drive, active-low one-hot
//  key_valid  out  1   one-cycle pulse when a debounced key is accepted
//  key_code   out  4   code of the last accepted key, valid from the key_valid cycle on
//  data32     out  32  assembled word; newest digit in [3:0]
// BEHAVIOUR
//  Reset (clr=0): col=4'b1110, key_valid=0, key_code=0, data32=0, FSM=SCAN, all counters 0.
//  - row passes through a 2-FF synchronizer (row_s); decisions use row_s only.
//  - Sync latency is 2 cycles, so the column dwell must be >=4 cycles.
//  Key map: row index r (0..3), column index c (0..3) -> code = {r[1:0],c[1:0]}.
//  Several rows low at once: the lowest-index row wins.
//  FSM states:
//  - SCAN: the dwell counter counts 0..SCAN_DIV-1.
//    - At terminal count with row_s==4'hF: rotate col left (1110->1101->1011->0111->1110), dwell restarts.
//    - At terminal count with any row_s bit 0: latch row_s and col into cand, freeze col, counter=0, go DEB_PRESS.
//  - DEB_PRESS: counts while row_s==cand row pattern.
//    - Any mismatch: back to SCAN, col unchanged, dwell restarts.
//    - Count reaches DEBOUNCE_CYC-1: next cycle key_valid=1, key_code<=code, data32<={data32[27:0],code}, go HOLD.
//  - HOLD: col stays frozen; counts consecutive cycles with row_s==4'hF.
//    - Any low row resets the count to 0.
//    - Count reaches DEBOUNCE_CYC-1: go SCAN, col advances to the next column.
//  Auto-repeat: none. A held key produces exactly one key_valid.
//  data32 wrap: the 9th digit shifts the oldest nibble out of [31:28], which is lost.
//  Reset asserted mid-debounce or mid-hold: everything returns to reset values; no partial key is recorded.
//  key_valid is never high for two consecutive cycles.
//  Counter widths come from $clog2 of the parameters; no overflow is possible because every counter stops at its terminal count.
// CONFIGURATION
//  Macro HEX_KEYPAD_EDIT_EN:
//  - Defined: code 4'hE is backspace (data32<={4'h0,data32[31:4]}) and code 4'hF clears data32 to 0.
//    key_valid and key_code still pulse/update for these keys.
//  - Undefined: all 16 codes are shifted into data32 identically.
// STRUCTURE
//  Package keypad_pkg holds:
//  - FSM state encoding (SCAN, DEB_PRESS, HOLD)
//  - COL_RESET=4'b1110, ROW_IDLE=4'hF
//  - KEY_BKSP=4'hE, KEY_CLR=4'hF
//  - the row/col-to-code function
//  Sub-module keypad_stable_cnt: an up-counter with terminal-count flag and synchronous restart.
//  - Instanced twice: column dwell and debounce. The FSM and data32 datapath live in the top module.
// TESTING
//  (Bench uses SCAN_DIV=4, DEBOUNCE_CYC=8.)
//  1. No keys pressed for 64 cycles -> col cycles 1110,1101,1011,0111 every 4 cycles; key_valid stays 0; data32=0.
//  2. Press row1/col2 cleanly for 30 cycles, then release -> exactly one key_valid; key_code=4'h6; data32=32'h0000_0006.
//  3. Bounce row1/col2 (low 3 cycles, high 2 cycles, repeated) -> no key_valid; then hold it stable -> one key 6 accepted.
//  4. Enter keys 1,2,...,9 in sequence -> data32=32'h2345_6789 (digit 1 lost); nine key_valid pulses.
//  5. Pull clr low during DEB_PRESS -> col=1110, data32 unchanged from 0, no key_valid; normal scanning resumes after release.
//  6. With HEX_KEYPAD_EDIT_EN defined: enter A, B, then E -> data32=32'h0000_000A; then F -> data32=0.
//     With the macro undefined, the same sequence gives 32'h0000_ABEF.

Source files
------------

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 hex keypad reader.
//   - FSM state encoding (SCAN, DEB_PRESS, HOLD)
//   - Idle/reset patterns for the active-low row and column buses
//   - Edit key codes (used only when HEX_KEYPAD_EDIT_EN is defined)
//   - key_code_of(): row/column pattern to 4-bit key code
// No ports (package).
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam logic [1:0] SCAN      = 2'd0;
    localparam logic [1:0] DEB_PRESS = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROW_IDLE  = 4'hF;

    localparam logic [3:0] KEY_BKSP  = 4'hE;
    localparam logic [3:0] KEY_CLR   = 4'hF;

    // code = {row index, column index}; with several rows low the
    // lowest-index row wins.
    function automatic logic [3:0] key_code_of(input logic [3:0] row_pat,
                                               input logic [3:0] col_pat);
        logic [1:0] r;
        logic [1:0] c;
        casez (row_pat)
            4'b???0: r = 2'd0;
            4'b??01: r = 2'd1;
            4'b?011: r = 2'd2;
            default: r = 2'd3;
        endcase
        case (col_pat)
            4'b1110: c = 2'd0;
            4'b1101: c = 2'd1;
            4'b1011: c = 2'd2;
            default: c = 2'd3;
        endcase
        return {r, c};
    endfunction

endpackage

// File: rtl/keypad_stable_cnt.sv
// -----------------------------------------------------------------------------
// keypad_stable_cnt
// Up-counter that saturates at LIMIT-1 and raises tc while it sits there.
// A synchronous restart returns it to 0.
// Ports:
//   clk      in  1  system clock
//   clr      in  1  asynchronous active-low reset
//   restart  in  1  synchronous return to 0 (has priority over counting)
//   tc       out 1  count == LIMIT-1
// -----------------------------------------------------------------------------
module keypad_stable_cnt #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic tc
);

    localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;

    assign tc = (cnt == W'(LIMIT - 1));

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (!tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hex_keypad_reader.sv
// -----------------------------------------------------------------------------
// hex_keypad_reader
// Scans a 4x4 active-low matrix keypad one column at a time, debounces press
// and release, and shifts each accepted key code into a 32-bit word.
// Parameters:
//   SCAN_DIV      clk cycles each column is driven low (>=4)
//   DEBOUNCE_CYC  stable cycles required for press and for release (>=2)
// Ports:
//   clk        in   1  system clock
//   clr        in   1  asynchronous active-low reset
//   row        in   4  keypad rows, active-low, asynchronous
//   col        out  4  column drive, active-low one-hot
//   key_valid  out  1  one-cycle pulse per accepted key
//   key_code   out  4  last accepted key code
//   data32     out 32  assembled word, newest digit in [3:0]
// Configuration:
//   HEX_KEYPAD_EDIT_EN  when defined, key E is backspace and key F clears
//                       data32; otherwise every key is shifted in.
// -----------------------------------------------------------------------------
module hex_keypad_reader
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CYC = 20000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] data32
);

    logic [3:0]  row_m;
    logic [3:0]  row_s;
    logic [1:0]  state;
    logic [3:0]  cand_row;
    logic        dwell_restart;
    logic        dwell_tc;
    logic        deb_restart;
    logic        deb_tc;
    logic [3:0]  new_code;
    logic [31:0] next_data;

    // NOTE: the synchronizer resets to the idle row pattern, not 0; a zero
    // reset value would look like every key pressed on the first scan.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            row_m <= ROW_IDLE;
            row_s <= ROW_IDLE;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    // The column is frozen outside SCAN, so the current col is the
    // candidate column.
    assign new_code = key_code_of(cand_row, col);

    // NOTE: every signal written here gets a default first, so no latch is
    // inferred on paths a case arm does not mention.
    always_comb begin
        dwell_restart = 1'b1;
        deb_restart   = 1'b1;
        case (state)
            SCAN:      dwell_restart = dwell_tc;
            DEB_PRESS: deb_restart   = (row_s != cand_row) || deb_tc;
            HOLD:      deb_restart   = (row_s != ROW_IDLE);
            default: ;
        endcase
    end

    always_comb begin
`ifdef HEX_KEYPAD_EDIT_EN
        if (new_code == KEY_BKSP) begin
            next_data = {4'h0, data32[31:4]};
        end else if (new_code == KEY_CLR) begin
            next_data = '0;
        end else begin
            next_data = {data32[27:0], new_code};
        end
`else
        next_data = {data32[27:0], new_code};
`endif
    end

    keypad_stable_cnt #(.LIMIT(SCAN_DIV)) u_dwell (
        .clk     (clk),
        .clr     (clr),
        .restart (dwell_restart),
        .tc      (dwell_tc)
    );

    keypad_stable_cnt #(.LIMIT(DEBOUNCE_CYC)) u_debounce (
        .clk     (clk),
        .clr     (clr),
        .restart (deb_restart),
        .tc      (deb_tc)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= SCAN;
            col       <= COL_RESET;
            cand_row  <= ROW_IDLE;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            data32    <= '0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell_tc) begin
                        if (row_s == ROW_IDLE) begin
                            col <= {col[2:0], col[3]};
                        end else begin
                            cand_row <= row_s;
                            state    <= DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (row_s != cand_row) begin
                        state <= SCAN;
                    end else if (deb_tc) begin
                        key_valid <= 1'b1;
                        key_code  <= new_code;
                        data32    <= next_data;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    // Leaving HOLD moves on to the next column so a key
                    // still bouncing at release is not re-detected at once.
                    if (row_s == ROW_IDLE && deb_tc) begin
                        state <= SCAN;
                        col   <= {col[2:0], col[3]};
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
